// File: rtl/logic_axi4_stream_mux_if.sv
// AXI4-Stream signal bundle. The rx modport is the receiving side of a
// stream (the mux inputs), the tx modport the sending side (the mux output).
interface logic_axi4_stream_if #(
   parameter int TDATA_BYTES = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TID_WIDTH   = 1
);
   logic                     tvalid;
   logic                     tready;
   logic [8*TDATA_BYTES-1:0] tdata;
   logic [TDATA_BYTES-1:0]   tkeep;
   logic [TDATA_BYTES-1:0]   tstrb;
   logic                     tlast;
   logic [TUSER_WIDTH-1:0]   tuser;
   logic [TDEST_WIDTH-1:0]   tdest;
   logic [TID_WIDTH-1:0]     tid;

   modport rx (
      input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
      output tready
   );

   modport tx (
      output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
      input  tready
   );
endinterface

// File: rtl/logic_axi4_stream_mux.sv
// Round-robin AXI4-Stream multiplexer with packet locking and a single
// output register slice; optionally retags tid/tdest with the source index.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | no owner; pick the next requester after last_grant
//   ST_LOCKED | grant_q owns the output until its tlast beat (or one beat)
module logic_axi4_stream_mux #(
   parameter int INPUTS      = 2,
   parameter int TDATA_BYTES = 1,
   parameter int TDEST_WIDTH = 1,
   parameter int TUSER_WIDTH = 1,
   parameter int TID_WIDTH   = 1,
   parameter bit USE_TLAST   = 1'b1,
   parameter bit USE_TKEEP   = 1'b1,
   parameter bit USE_TSTRB   = 1'b1,
   parameter bit USE_TID     = 1'b1,
   parameter bit TAG         = 1'b1,
   localparam int TAG_W      = USE_TID ? TID_WIDTH : TDEST_WIDTH,
   parameter logic [INPUTS*TAG_W-1:0] MAP = identity_map()
) (
   input  logic            aclk,
   input  logic            areset,
   logic_axi4_stream_if.rx rx [INPUTS],
   logic_axi4_stream_if.tx tx
);

   function automatic logic [INPUTS*TAG_W-1:0] identity_map();
      logic [INPUTS*TAG_W-1:0] m;
      m = '0;
      for (int i = 0; i < INPUTS; i++) begin
         m[i*TAG_W +: TAG_W] = TAG_W'(i);
      end
      return m;
   endfunction

   localparam int DW = 8 * TDATA_BYTES;
   localparam int KW = TDATA_BYTES;
   localparam int GW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
   localparam logic [GW-1:0] LAST_IDX = GW'(INPUTS - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] last_grant_q, last_grant_d;

   logic [INPUTS-1:0]      rx_tvalid;
   logic [INPUTS-1:0]      rx_tready;
   logic [INPUTS-1:0]      rx_tlast;
   logic [DW-1:0]          rx_tdata [INPUTS];
   logic [KW-1:0]          rx_tkeep [INPUTS];
   logic [KW-1:0]          rx_tstrb [INPUTS];
   logic [TUSER_WIDTH-1:0] rx_tuser [INPUTS];
   logic [TDEST_WIDTH-1:0] rx_tdest_eff [INPUTS];
   logic [TID_WIDTH-1:0]   rx_tid_eff [INPUTS];

   logic                   tvalid_q, tvalid_d;
   logic [DW-1:0]          tdata_q, tdata_d;
   logic [KW-1:0]          tkeep_q, tkeep_d;
   logic [KW-1:0]          tstrb_q, tstrb_d;
   logic                   tlast_q, tlast_d;
   logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
   logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
   logic [TID_WIDTH-1:0]   tid_q, tid_d;

   logic          any_req;
   logic [GW-1:0] pick;
   logic [GW-1:0] cand;
   logic          slot_free;
   logic          beat_acc;
   logic          end_of_lock;

   // The tag substitution is resolved per input so the output mux only
   // ever sees the effective tid/tdest of each source.
   for (genvar gi = 0; gi < INPUTS; gi++) begin : g_rx
      assign rx_tvalid[gi]  = rx[gi].tvalid;
      assign rx_tlast[gi]   = rx[gi].tlast;
      assign rx_tdata[gi]   = rx[gi].tdata;
      assign rx_tkeep[gi]   = rx[gi].tkeep;
      assign rx_tstrb[gi]   = rx[gi].tstrb;
      assign rx_tuser[gi]   = rx[gi].tuser;
      assign rx[gi].tready  = rx_tready[gi];

      if (TAG && USE_TID) begin : g_tid_map
         assign rx_tid_eff[gi] = MAP[gi*TAG_W +: TAG_W];
      end else begin : g_tid_pass
         assign rx_tid_eff[gi] = rx[gi].tid;
      end

      if (TAG && !USE_TID) begin : g_tdest_map
         assign rx_tdest_eff[gi] = MAP[gi*TAG_W +: TAG_W];
      end else begin : g_tdest_pass
         assign rx_tdest_eff[gi] = rx[gi].tdest;
      end
   end

   always_comb begin
      any_req = 1'b0;
      pick    = last_grant_q;
      cand    = last_grant_q;
      for (int k = 0; k < INPUTS; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + GW'(1);
         if (!any_req && rx_tvalid[cand]) begin
            any_req = 1'b1;
            pick    = cand;
         end
      end
   end

   assign slot_free = !tvalid_q || tx.tready;

   always_comb begin
      rx_tready = '0;
      if ((state_q == ST_LOCKED) && slot_free && !areset) begin
         rx_tready[grant_q] = 1'b1;
      end
   end

   assign beat_acc    = rx_tvalid[grant_q] && rx_tready[grant_q];
   assign end_of_lock = beat_acc && (rx_tlast[grant_q] || !USE_TLAST);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d      = ST_LOCKED;
               grant_d      = pick;
               last_grant_d = pick;
            end
         end
         ST_LOCKED: begin
            if (end_of_lock) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tstrb_d  = tstrb_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      tdest_d  = tdest_q;
      tid_d    = tid_q;
      if (beat_acc) begin
         tvalid_d = 1'b1;
         tdata_d  = rx_tdata[grant_q];
         tkeep_d  = rx_tkeep[grant_q];
         tstrb_d  = rx_tstrb[grant_q];
         tlast_d  = rx_tlast[grant_q];
         tuser_d  = rx_tuser[grant_q];
         tdest_d  = rx_tdest_eff[grant_q];
         tid_d    = rx_tid_eff[grant_q];
      end else if (tx.tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_IDX;
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
         tkeep_q      <= '0;
         tstrb_q      <= '0;
         tlast_q      <= 1'b0;
         tuser_q      <= '0;
         tdest_q      <= '0;
         tid_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         tvalid_q     <= tvalid_d;
         tdata_q      <= tdata_d;
         tkeep_q      <= tkeep_d;
         tstrb_q      <= tstrb_d;
         tlast_q      <= tlast_d;
         tuser_q      <= tuser_d;
         tdest_q      <= tdest_d;
         tid_q        <= tid_d;
      end
   end

   assign tx.tvalid = tvalid_q;
   assign tx.tdata  = tdata_q;
   assign tx.tkeep  = USE_TKEEP ? tkeep_q : '1;
   assign tx.tstrb  = USE_TSTRB ? tstrb_q : '1;
   assign tx.tlast  = USE_TLAST ? tlast_q : 1'b1;
   assign tx.tuser  = tuser_q;
   assign tx.tdest  = tdest_q;
   assign tx.tid    = tid_q;

endmodule

// File: tb/tb_logic_axi4_stream_mux.sv
// Bench for logic_axi4_stream_mux: directed scenarios plus randomized packets,
// checked against a packet-level round-robin model of the merged stream.
module tb_logic_axi4_stream_mux;
   localparam int INPUTS = 2;

   logic aclk   = 1'b0;
   logic areset = 1'b1;
   always #5 aclk = ~aclk;

   logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)) rx_if [INPUTS] ();
   logic_axi4_stream_if #(.TDATA_BYTES(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1), .TID_WIDTH(1)) tx_if ();

   logic_axi4_stream_mux #(.INPUTS(INPUTS)) dut (
      .aclk   (aclk),
      .areset (areset),
      .rx     (rx_if),
      .tx     (tx_if)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       strb;
      logic       last;
      logic       user;
      logic       dest;
      logic       id;
   } beat_t;

   beat_t             drv [INPUTS];
   logic              drv_v [INPUTS];
   logic [INPUTS-1:0] rdy_vec;
   logic              tx_rdy;
   beat_t             tx_obs;

   for (genvar g = 0; g < INPUTS; g++) begin : g_drv
      assign rx_if[g].tvalid = drv_v[g];
      assign rx_if[g].tdata  = drv[g].data;
      assign rx_if[g].tkeep  = drv[g].keep;
      assign rx_if[g].tstrb  = drv[g].strb;
      assign rx_if[g].tlast  = drv[g].last;
      assign rx_if[g].tuser  = drv[g].user;
      assign rx_if[g].tdest  = drv[g].dest;
      assign rx_if[g].tid    = drv[g].id;
      assign rdy_vec[g]      = rx_if[g].tready;
   end
   assign tx_if.tready = tx_rdy;
   assign tx_obs = {tx_if.tdata, tx_if.tkeep, tx_if.tstrb, tx_if.tlast,
                    tx_if.tuser, tx_if.tdest, tx_if.tid};

   beat_t inq [INPUTS][$];
   beat_t expq[$];
   int    acc_cyc[$];
   int    out_cyc[$];
   bit    mid [INPUTS];
   int    gap_force [INPUTS];
   bit    gap_rand, rdy_rand, lat_chk, rst_req, hold_chk;
   int    bp_cnt, cyc, n_vec, n_err;
   beat_t held;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit done();
      bit d;
      d = (expq.size() == 0);
      for (int i = 0; i < INPUTS; i++) if (inq[i].size() != 0) d = 1'b0;
      return d;
   endfunction

   // One clock: drive at the falling edge, observe 1 time unit later.
   task automatic cycle();
      beat_t e;
      bit    gap;
      @(negedge aclk);
      areset = rst_req;
      for (int i = 0; i < INPUTS; i++) begin
         gap = 1'b0;
         if (mid[i] && gap_force[i] > 0) begin
            gap = 1'b1;
            gap_force[i]--;
         end else if (mid[i] && gap_rand && $urandom_range(0, 3) == 0) begin
            gap = 1'b1;
         end
         if (inq[i].size() > 0 && !gap) begin
            drv_v[i] = 1'b1;
            drv[i]   = inq[i][0];
         end else begin
            drv_v[i] = 1'b0;
            drv[i]   = '0;
         end
      end
      if (bp_cnt > 0) begin
         tx_rdy = 1'b0;
         bp_cnt--;
      end else begin
         tx_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      if (hold_chk) begin
         chk("hold_tvalid", tx_if.tvalid, 1);
         chk("hold_payload", tx_obs, held);
      end
      if (tx_if.tvalid && !tx_rdy) chk("rx_tready_while_stalled", rdy_vec, 0);
      if (tx_if.tvalid && tx_rdy && !areset) begin
         chk("beat_expected", 32'(expq.size() != 0), 1);
         if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("tx_beat", tx_obs, e);
            if (lat_chk) begin
               chk("latency_src", 32'(acc_cyc.size() != 0), 1);
               if (acc_cyc.size() != 0) chk("latency", cyc, acc_cyc.pop_front() + 1);
            end
         end
         out_cyc.push_back(cyc);
      end
      hold_chk = tx_if.tvalid && !tx_rdy && !areset;
      held     = tx_obs;
      for (int i = 0; i < INPUTS; i++) begin
         if (drv_v[i] && rdy_vec[i]) begin
            void'(inq[i].pop_front());
            mid[i] = !drv[i].last;
            if (lat_chk) acc_cyc.push_back(cyc);
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      cycle();
      @(posedge aclk);
      #1;
      chk("rst_tvalid", tx_if.tvalid, 0);
      chk("rst_rx_tready", rdy_vec, 0);
      chk("rst_payload", tx_obs, 0);
      rst_req = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         inq[i].delete();
         mid[i]       = 1'b0;
         gap_force[i] = 0;
      end
      expq.delete();
      acc_cyc.delete();
      out_cyc.delete();
      hold_chk = 1'b0;
      bp_cnt   = 0;
   endtask

   task automatic load_pkt(input int i, input int len, input int base, input bit rnd);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = rnd ? 8'($urandom) : 8'(base + k);
         b.keep = 1'($urandom);
         b.strb = 1'($urandom);
         b.user = 1'($urandom);
         b.dest = 1'($urandom);
         b.id   = 1'($urandom);
         b.last = (k == len - 1);
         inq[i].push_back(b);
      end
   endtask

   // Whole packets leave in round-robin order over the inputs that still
   // hold packets, starting after input INPUTS-1; tid becomes the source.
   task automatic build_exp();
      beat_t q [INPUTS][$];
      beat_t b;
      int    last, s;
      for (int i = 0; i < INPUTS; i++) q[i] = inq[i];
      last = INPUTS - 1;
      s    = 0;
      while (s >= 0) begin
         s = -1;
         for (int k = 1; k <= INPUTS; k++) begin
            if (s < 0 && q[(last + k) % INPUTS].size() > 0) s = (last + k) % INPUTS;
         end
         if (s >= 0) begin
            do begin
               b    = q[s].pop_front();
               b.id = 1'(s);
               expq.push_back(b);
            end while (!b.last);
            last = s;
         end
      end
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while (!done() && n < max_cyc) begin
         cycle();
         n++;
      end
      chk("drain_complete", 32'(done()), 1);
   endtask

   initial begin
      int n;
      n_vec = 0; n_err = 0; cyc = 0;
      rst_req = 1'b1; tx_rdy = 1'b1; bp_cnt = 0; hold_chk = 1'b0;
      gap_rand = 1'b0; rdy_rand = 1'b0; lat_chk = 1'b0;
      for (int i = 0; i < INPUTS; i++) begin
         drv_v[i] = 1'b0; drv[i] = '0; mid[i] = 1'b0; gap_force[i] = 0;
      end

      // single input, 3-beat packet on rx[1]
      do_reset();
      lat_chk = 1'b1;
      load_pkt(1, 3, 'hA1, 1'b0);
      build_exp();
      drain(50);
      chk("single_beats", out_cyc.size(), 3);
      if (out_cyc.size() == 3) chk("single_back_to_back", out_cyc[2] - out_cyc[0], 2);

      // contention: both inputs start together
      do_reset();
      load_pkt(0, 2, 'h10, 1'b0);
      load_pkt(1, 2, 'h20, 1'b0);
      build_exp();
      drain(50);

      // fairness with 1-beat packets: one idle cycle between grants
      do_reset();
      for (int k = 0; k < 4; k++) begin
         load_pkt(0, 1, 'h30 + k, 1'b0);
         load_pkt(1, 1, 'h40 + k, 1'b0);
      end
      build_exp();
      drain(100);
      chk("rr_beats", out_cyc.size(), 8);
      for (int k = 1; k < out_cyc.size(); k++) chk("rr_spacing", out_cyc[k] - out_cyc[k-1], 2);

      // backpressure for 4 cycles mid-packet
      do_reset();
      lat_chk = 1'b0;
      load_pkt(0, 4, 'h50, 1'b0);
      load_pkt(1, 2, 'h58, 1'b0);
      build_exp();
      n = 0;
      while (out_cyc.size() < 2 && n < 20) begin
         cycle();
         n++;
      end
      chk("bp_reached", out_cyc.size(), 2);
      bp_cnt = 4;
      drain(50);

      // granted input drops tvalid mid-packet while the other requests
      do_reset();
      load_pkt(0, 3, 'h60, 1'b0);
      load_pkt(1, 1, 'h70, 1'b0);
      gap_force[0] = 2;
      build_exp();
      drain(50);

      // reset during the 2nd beat of a 4-beat packet
      do_reset();
      load_pkt(1, 4, 'h80, 1'b0);
      build_exp();
      n = 0;
      while (inq[1].size() > 3 && n < 20) begin
         cycle();
         n++;
      end
      chk("rst_mid_reached", inq[1].size(), 3);
      do_reset();
      for (int k = 0; k < 4; k++) cycle();
      chk("rst_mid_no_beats", out_cyc.size(), 0);
      load_pkt(0, 2, 'h90, 1'b0);
      build_exp();
      drain(50);

      // randomized packets, random tready and mid-packet gaps
      gap_rand = 1'b1;
      rdy_rand = 1'b1;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < INPUTS; i++) begin
            n = $urandom_range(2, 5);
            for (int p = 0; p < n; p++) load_pkt(i, $urandom_range(1, 4), 0, 1'b1);
         end
         build_exp();
         drain(2000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
